// File: rtl/capture_buffer.sv
// capture_buffer: circular pre/post-trigger sample store that streams
// the finished record on a valid/ready port, then pulses transfer-done.
module capture_buffer #(
   parameter int DATA_W  = 12,
   parameter int DEPTH   = 1024,
   parameter int PRETRIG = 256
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_response_valid,
   input  logic [DATA_W-1:0] i_sample_data,
   input  logic              i_trigger,
   input  logic              i_rd_ready,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_last,
   output logic              o_TRANSFER_DONE,
   output logic              o_busy
);

   localparam int ADDR_W = $clog2(DEPTH);

   localparam logic [ADDR_W:0] FILL_LAST = (ADDR_W+1)'(PRETRIG);
   localparam logic [ADDR_W:0] POST_LAST = (ADDR_W+1)'(DEPTH-PRETRIG-2);
   localparam logic [ADDR_W:0] REC_LEN   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] REC_LAST  = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0] CNT_ONE   = 1;
   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam bit POST_ONE = (DEPTH - PRETRIG - 1) == 1;

   typedef enum logic [2:0] {
      S_FILL,
      S_ARMED,
      S_POST,
      S_READ,
      S_DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   cnt;
   logic              rd_valid;
   logic              rd_last;
   logic              wr_en;
   logic              fetch;
   logic              xfer;
   logic              enter_read;

   assign xfer       = rd_valid && i_rd_ready;
   assign fetch      = (state_q == S_READ) && (cnt != REC_LEN)
                       && (!rd_valid || i_rd_ready);
   assign enter_read = (state_d == S_READ) && (state_q != S_READ);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      wr_en   = 1'b0;
      state_d = state_q;
      unique case (state_q)
         S_FILL: begin
            wr_en = i_response_valid;
            if (wr_en && cnt == FILL_LAST) state_d = S_ARMED;
         end
         S_ARMED: begin
            wr_en = i_response_valid;
            if (i_trigger) begin
               state_d = (wr_en && POST_ONE) ? S_READ : S_POST;
            end
         end
         S_POST: begin
            wr_en = i_response_valid;
            if (wr_en && cnt == POST_LAST) state_d = S_READ;
         end
         S_READ: begin
            if (xfer && rd_last) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_FILL;
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         if (state_q == S_DONE) begin
            wr_ptr <= '0;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end

         // Oldest entry sits just past the final post-trigger write.
         if (enter_read) begin
            rd_ptr <= wr_ptr + PTR_ONE;
         end else if (fetch) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end

         unique case (state_q)
            S_FILL: begin
               if (wr_en) cnt <= (state_d == S_ARMED) ? '0 : cnt + CNT_ONE;
            end
            S_ARMED: begin
               if (i_trigger) begin
                  cnt <= (state_d == S_POST && wr_en) ? CNT_ONE : '0;
               end
            end
            S_POST: begin
               if (wr_en) cnt <= (state_d == S_READ) ? '0 : cnt + CNT_ONE;
            end
            S_READ: begin
               if (fetch) cnt <= cnt + CNT_ONE;
            end
            default: begin
               cnt <= '0;
            end
         endcase

         if (fetch) begin
            rd_valid <= 1'b1;
            rd_last  <= (cnt == REC_LAST);
         end else if (xfer) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
         end
      end
   end

   // Read register only advances on fetch, so it holds under stall.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_ptr] <= i_sample_data;
      if (fetch) ram_q <= mem[rd_ptr];
   end

   assign o_rd_valid      = rd_valid;
   assign o_rd_data       = rd_valid ? ram_q : '0;
   assign o_rd_last       = rd_last;
   assign o_TRANSFER_DONE = (state_q == S_DONE);
   assign o_busy          = (state_q == S_POST) || (state_q == S_READ)
                            || (state_q == S_DONE);

endmodule
